// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM handshake encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Arbiter grant states and starvation counter width.
package diaosi_types_pkg;

   typedef enum logic [1:0] {
      IDLE,
      IGRANT,
      DREAD,
      DWRITE
   } arbstate_t;

   localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache fill and dcache access; data side wins unless starved.
// Optional ARB_STATS_EN adds completion and error counters (icount, dcount, ecount).
module mem_arbiter
   import cpu_types_pkg::*;
   import diaosi_types_pkg::*;
#(
   parameter int unsigned WORD_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate
`ifdef ARB_STATS_EN
   ,
   output word_t             icount,
   output word_t             dcount,
   output word_t             ecount
`endif
);

   localparam logic [STARVE_W-1:0] Limit = STARVE_W'(STARVE_LIMIT);

   arbstate_t           state_q, state_d;
   logic [STARVE_W-1:0] cnt_q, cnt_d;
   ramstate_t           rs;
   logic                i_done, d_done;

   assign rs = ramstate_t'(ramstate);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      i_done   = 1'b0;
      d_done   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (iREN && cnt_q == Limit) state_d = IGRANT;
            else if (dWEN)              state_d = DWRITE;
            else if (dREN)              state_d = DREAD;
            else if (iREN)              state_d = IGRANT;
         end
         IGRANT: begin
            // A dropped request aborts: strobes stay low and we return to IDLE silently.
            if (!iREN) begin
               state_d = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (rs == ACCESS) begin
                  iwait   = 1'b0;
                  iload   = ramload;
                  i_done  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         DREAD: begin
            if (!dREN) begin
               state_d = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = daddr;
               if (rs == ACCESS) begin
                  dwait   = 1'b0;
                  dload   = ramload;
                  d_done  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         DWRITE: begin
            if (!dWEN) begin
               state_d = IDLE;
            end else begin
               ramWEN   = 1'b1;
               ramaddr  = daddr;
               ramstore = dstore;
               if (rs == ACCESS) begin
                  dwait   = 1'b0;
                  d_done  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_q == IDLE && !iREN) || i_done) begin
         cnt_d = '0;
      end else if (d_done && iREN && cnt_q < Limit) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef ARB_STATS_EN
   word_t icount_q, dcount_q, ecount_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         icount_q <= '0;
         dcount_q <= '0;
         ecount_q <= '0;
      end else begin
         if (i_done) icount_q <= icount_q + 32'd1;
         if (d_done) dcount_q <= dcount_q + 32'd1;
         if (state_q != IDLE && rs == ERROR) ecount_q <= ecount_q + 32'd1;
      end
   end

   assign icount = icount_q;
   assign dcount = dcount_q;
   assign ecount = ecount_q;
`endif

endmodule
